// File: rtl/round_timing_controller.sv
`timescale 1ns/1ps
// Reaction-round timer: starts a round, counts tick_1ms until a press or the round limit, pauses, repeats.
// Latency: event flags (trigger/timeout/acerto) appear one cycle after the causing edge; gerar_jogada/fim_jogo follow state directly.
// No backpressure: inputs are single-cycle pulses sampled every clock; optional scoring via macro ROUND_SCORE_EN.
module round_timing_controller #(
  parameter int N_RODADAS   = 10,
  parameter int PAUSA_TICKS = 500,
  parameter int TOLERANCIA  = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       tick_1ms,
  input  logic [1:0] nivel_dificuldade,
  output logic       gerar_jogada,
  output logic       trigger,
  output logic [9:0] contador_jogo,
  output logic [9:0] mid_idx,
  output logic [9:0] max_idx,
  output logic       timeout,
  output logic       acerto,
  output logic [3:0] rodada,
  output logic       fim_jogo,
  output logic [7:0] pontos,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GERA   = 3'd1,
    S_CONTA  = 3'd2,
    S_RESULT = 3'd3,
    S_FIM    = 3'd4
  } estado_t;

  localparam logic [9:0] TOL_V       = 10'(TOLERANCIA);
  localparam logic [9:0] PAUSA_LAST  = 10'(PAUSA_TICKS - 1);
  localparam logic [3:0] RODADA_LAST = 4'(N_RODADAS - 1);

  estado_t    r_estado;
  estado_t    w_prox;
  logic [9:0] r_cont;
  logic [9:0] r_max;
  logic [9:0] r_mid;
  logic [9:0] r_pausa;
  logic [3:0] r_rodada;
  logic       r_trigger;
  logic       r_timeout;
  logic       r_acerto;

  logic       w_start;
  logic       w_press;
  logic       w_terminal;
  logic       w_pausa_fim;
  logic       w_hit;
  logic [9:0] w_max_sel;
  logic [9:0] w_diff;

  // Round length for the requested difficulty (levels 10 and 11 share the shortest round)
  always_comb begin
    w_max_sel = 10'd400;
    case (nivel_dificuldade)
      2'b00:   w_max_sel = 10'd800;
      2'b01:   w_max_sel = 10'd600;
      default: w_max_sel = 10'd400;
    endcase
  end

  // Unsigned distance between the live count and the target; ordered subtraction so it never wraps
  always_comb begin
    w_diff = (r_cont >= r_mid) ? (r_cont - r_mid) : (r_mid - r_cont);
    w_hit  = (w_diff <= TOL_V);
  end

  // Next-state decode plus the single-cycle events that drive the datapath
  always_comb begin
    w_prox       = r_estado;
    w_start      = 1'b0;
    w_press      = 1'b0;
    w_terminal   = 1'b0;
    w_pausa_fim  = 1'b0;
    gerar_jogada = 1'b0;
    fim_jogo     = 1'b0;
    case (r_estado)
      S_IDLE: begin
        if (iniciar) begin
          w_start = 1'b1;
          w_prox  = S_GERA;
        end
      end
      S_GERA: begin
        gerar_jogada = 1'b1;
        w_prox       = S_CONTA;
      end
      S_CONTA: begin
        // A press on the same edge as the final tick takes priority over the timeout
        if (jogada_feita) begin
          w_press = 1'b1;
          w_prox  = S_RESULT;
        end else if (tick_1ms && (r_cont == (r_max - 10'd1))) begin
          w_terminal = 1'b1;
          w_prox     = S_RESULT;
        end
      end
      S_RESULT: begin
        if (tick_1ms && (r_pausa == PAUSA_LAST)) begin
          w_pausa_fim = 1'b1;
          w_prox      = (r_rodada == RODADA_LAST) ? S_FIM : S_GERA;
        end
      end
      S_FIM: begin
        fim_jogo = 1'b1;
        if (iniciar) begin
          w_start = 1'b1;
          w_prox  = S_GERA;
        end
      end
      default: w_prox = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_estado <= S_IDLE;
    else       r_estado <= w_prox;
  end

  // Round datapath: count, limits, pause timer, round counter and registered result pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cont    <= 10'd0;
      r_max     <= 10'd800;
      r_mid     <= 10'd400;
      r_pausa   <= 10'd0;
      r_rodada  <= 4'd0;
      r_trigger <= 1'b0;
      r_timeout <= 1'b0;
      r_acerto  <= 1'b0;
    end else begin
      // GERA always lasts one cycle, so this yields a single pulse in the first CONTA cycle
      r_trigger <= (r_estado == S_GERA);
      r_timeout <= w_terminal;
      r_acerto  <= w_press && w_hit;

      if (w_start)          r_rodada <= 4'd0;
      else if (w_pausa_fim) r_rodada <= r_rodada + 4'd1;

      if (r_estado == S_GERA) begin
        r_cont <= 10'd0;
        r_max  <= w_max_sel;
        r_mid  <= w_max_sel >> 1;
      end else if ((r_estado == S_CONTA) && !jogada_feita && tick_1ms) begin
        r_cont <= r_cont + 10'd1;
      end

      // Held at zero outside RESULTADO so every entry starts a fresh pause
      if (r_estado != S_RESULT) r_pausa <= 10'd0;
      else if (tick_1ms)        r_pausa <= r_pausa + 10'd1;
    end
  end

`ifdef ROUND_SCORE_EN
  logic [7:0] r_pontos;

  // Score: one point per hit, cleared at game start, saturating at 255
  always_ff @(posedge clock) begin
    if (reset)                                       r_pontos <= 8'd0;
    else if (w_start)                                r_pontos <= 8'd0;
    else if (w_press && w_hit && (r_pontos != 8'hFF)) r_pontos <= r_pontos + 8'd1;
  end

  assign pontos = r_pontos;
`else
  assign pontos = 8'd0;
`endif

  assign trigger       = r_trigger;
  assign timeout       = r_timeout;
  assign acerto        = r_acerto;
  assign contador_jogo = r_cont;
  assign max_idx       = r_max;
  assign mid_idx       = r_mid;
  assign rodada        = r_rodada;
  assign db_estado     = r_estado;

endmodule

// File: tb/tb_round_timing_controller.sv
`timescale 1ns/1ps
// Randomized bench for round_timing_controller: driver plans rounds and queues expected events,
// an independent monitor pops and compares whenever the DUT announces an event.
module tb_round_timing_controller;

  localparam int N_R = 2;
  localparam int P_T = 3;
  localparam int TOL = 50;

  localparam int EV_GER  = 0;
  localparam int EV_TRIG = 1;
  localparam int EV_RES  = 2;
  localparam int EV_FIM  = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       jogada_feita;
  logic       tick_1ms;
  logic [1:0] nivel_dificuldade;
  logic       gerar_jogada;
  logic       trigger;
  logic [9:0] contador_jogo;
  logic [9:0] mid_idx;
  logic [9:0] max_idx;
  logic       timeout;
  logic       acerto;
  logic [3:0] rodada;
  logic       fim_jogo;
  logic [7:0] pontos;
  logic [2:0] db_estado;

  always #5 clock = ~clock;

  round_timing_controller #(
    .N_RODADAS  (N_R),
    .PAUSA_TICKS(P_T),
    .TOLERANCIA (TOL)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .iniciar          (iniciar),
    .jogada_feita     (jogada_feita),
    .tick_1ms         (tick_1ms),
    .nivel_dificuldade(nivel_dificuldade),
    .gerar_jogada     (gerar_jogada),
    .trigger          (trigger),
    .contador_jogo    (contador_jogo),
    .mid_idx          (mid_idx),
    .max_idx          (max_idx),
    .timeout          (timeout),
    .acerto           (acerto),
    .rodada           (rodada),
    .fim_jogo         (fim_jogo),
    .pontos           (pontos),
    .db_estado        (db_estado)
  );

  typedef struct {
    int kind;
    int cnt;
    int maxi;
    int mid;
    int to;
    int ac;
    int rod;
    int pts;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference-model game state (driver side)
  int m_rod;
  int m_pts;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic int max_for(input int n);
    return (n == 0) ? 800 : (n == 1) ? 600 : 400;
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic push_ev(input int kind, input int cnt, input int maxi, input int mid,
                         input int to, input int ac, input int rod, input int pts);
    ev_t e;
    e.kind = kind; e.cnt = cnt; e.maxi = maxi; e.mid = mid;
    e.to = to; e.ac = ac; e.rod = rod; e.pts = pts;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic t, input logic p, input logic ini);
    tick_1ms     = t;
    jogada_feita = p;
    iniciar      = ini;
    @(posedge clock);
    #1;
    tick_1ms     = 1'b0;
    jogada_feita = 1'b0;
    iniciar      = 1'b0;
  endtask

  // Select difficulty for the coming GERA cycle and queue its two start-of-round events
  task automatic announce(input int n);
    nivel_dificuldade = 2'(n);
    push_ev(EV_GER, 0, 0, 0, 0, 0, m_rod, m_pts);
    push_ev(EV_TRIG, 0, max_for(n), max_for(n) / 2, 0, 0, 0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_estado"}, int'(db_estado), 0);
    chk({tag, "_cont"}, int'(contador_jogo), 0);
    chk({tag, "_max"}, int'(max_idx), 800);
    chk({tag, "_mid"}, int'(mid_idx), 400);
    chk({tag, "_rodada"}, int'(rodada), 0);
    chk({tag, "_pontos"}, int'(pontos), 0);
    chk({tag, "_pulses"}, int'({gerar_jogada, trigger, timeout, acerto}), 0);
    chk({tag, "_fim"}, int'(fim_jogo), 0);
  endtask

  // Plays one round starting in GERA; returns stopped=1 if a reset aborted it
  task automatic play_round(input int n, input int press_at, input bit ft, input int reset_at,
                            input int next_n, output bit stopped);
    int  k;
    int  pc;
    int  maxv;
    int  mid;
    bit  t;
    bit  hit;
    bit  done;
    stopped = 1'b0;
    maxv = max_for(n);
    mid  = maxv / 2;
    step(1'($urandom), 1'($urandom), 1'($urandom));
    nivel_dificuldade = 2'($urandom);
    k    = 0;
    done = 1'b0;
    while (!done) begin
      if (k == reset_at) begin
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        check_reset_state("midround_reset");
        m_rod   = 0;
        m_pts   = 0;
        stopped = 1'b1;
        return;
      end
      if (k == press_at) begin
        hit = (absd(k, mid) <= TOL);
`ifdef ROUND_SCORE_EN
        if (hit && m_pts < 255) m_pts++;
`endif
        push_ev(EV_RES, k, maxv, mid, 0, int'(hit), m_rod, m_pts);
        step(ft ? 1'b1 : 1'($urandom), 1'b1, 1'($urandom));
        done = 1'b1;
      end else begin
        t = (($urandom % 4) != 0);
        if (t && (k + 1 == maxv)) push_ev(EV_RES, maxv, maxv, mid, 1, 0, m_rod, m_pts);
        step(t, 1'b0, (($urandom % 16) == 0));
        if (t) k++;
        if (k == maxv) done = 1'b1;
      end
    end
    pc = 0;
    while (pc < P_T) begin
      t = 1'($urandom);
      if (t && (pc + 1 == P_T)) begin
        m_rod++;
        if (m_rod == N_R) push_ev(EV_FIM, 0, 0, 0, 0, 0, N_R, m_pts);
        else              announce(next_n);
      end
      step(t, 1'($urandom), 1'($urandom));
      if (t) pc++;
    end
  endtask

  // Monitor: pops expectations on each DUT event and checks invariants every cycle
  int  prev_st = 0;
  int  hold_cnt = 0;
  ev_t mon_e;
  bit  mon_ok;
  bit  entry3;
  bit  entry4;

  task automatic pop_ev(input int k, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{default: 0};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: DUT showed event kind %0d, scoreboard expected none", k);
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
      chk("event_kind", k, e.kind);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      prev_st = 0;
    end else begin
      entry3 = (db_estado == 3'd3) && (prev_st != 3);
      entry4 = (db_estado == 3'd4) && (prev_st != 4);
      if (gerar_jogada) begin
        pop_ev(EV_GER, mon_e, mon_ok);
        if (mon_ok) begin
          chk("gera_estado", int'(db_estado), 1);
          chk("gera_rodada", int'(rodada), mon_e.rod);
          chk("gera_pontos", int'(pontos), mon_e.pts);
        end
      end
      if (trigger) begin
        pop_ev(EV_TRIG, mon_e, mon_ok);
        if (mon_ok) begin
          chk("trig_estado", int'(db_estado), 2);
          chk("trig_max", int'(max_idx), mon_e.maxi);
          chk("trig_mid", int'(mid_idx), mon_e.mid);
          chk("trig_cont", int'(contador_jogo), 0);
        end
      end
      if (entry3) begin
        pop_ev(EV_RES, mon_e, mon_ok);
        if (mon_ok) begin
          chk("res_cont", int'(contador_jogo), mon_e.cnt);
          chk("res_timeout", int'(timeout), mon_e.to);
          chk("res_acerto", int'(acerto), mon_e.ac);
          chk("res_rodada", int'(rodada), mon_e.rod);
          chk("res_pontos", int'(pontos), mon_e.pts);
          hold_cnt = mon_e.cnt;
        end
      end else begin
        chk("no_stray_result_pulse", int'({timeout, acerto}), 0);
        if (db_estado == 3'd3) chk("pause_hold_cont", int'(contador_jogo), hold_cnt);
      end
      if (entry4) begin
        pop_ev(EV_FIM, mon_e, mon_ok);
        if (mon_ok) begin
          chk("fim_rodada", int'(rodada), mon_e.rod);
          chk("fim_level", int'(fim_jogo), 1);
          chk("fim_cont", int'(contador_jogo), hold_cnt);
          chk("fim_pontos", int'(pontos), mon_e.pts);
        end
      end else if (db_estado == 3'd4) begin
        chk("fim_hold_cont", int'(contador_jogo), hold_cnt);
        chk("fim_quiet", int'({gerar_jogada, trigger, timeout, acerto}), 0);
      end
      if (db_estado == 3'd2 || db_estado == 3'd3)
        chk("cont_le_max", int'(contador_jogo <= max_idx), 1);
      prev_st = int'(db_estado);
    end
  end

  // Driver: directed games first, then randomized ones
  initial begin
    int  rn[N_R];
    int  rp[N_R];
    bit  rft[N_R];
    int  rrst[N_R];
    int  mode;
    int  mv;
    bit  stopped;
    reset = 1'b1;
    iniciar = 1'b0;
    jogada_feita = 1'b0;
    tick_1ms = 1'b0;
    nivel_dificuldade = 2'd0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("por_reset");
    reset = 1'b0;
    for (int g = 0; g < 9; g++) begin
      for (int r = 0; r < N_R; r++) begin
        rft[r]  = 1'b0;
        rrst[r] = -1;
        rn[r]   = int'($urandom % 4);
        mv      = max_for(rn[r]);
        mode    = int'($urandom % 5);
        case (mode)
          0:       rp[r] = mv / 2 - 60 + int'($urandom % 121);
          1:       rp[r] = int'($urandom % mv);
          2:       rp[r] = -1;
          3:       rp[r] = mv / 2 + TOL;
          default: rp[r] = mv / 2 - TOL - 1;
        endcase
      end
      case (g)
        0: begin rn[0] = 0; rp[0] = -1;  rn[1] = 1; rp[1] = 300; end
        1: begin rn[0] = 2; rp[0] = -1;  rn[1] = 2; rp[1] = 399; rft[1] = 1'b1; end
        2: begin rn[0] = 3; rp[0] = -1;  rrst[0] = 123; end
        3: begin rn[0] = 2; rp[0] = -1;  rn[1] = 2; rp[1] = -1; end
        4: begin rn[0] = 1; rp[0] = 599; rft[0] = 1'b1; rn[1] = 0; rp[1] = 0; end
        default: ;
      endcase
      m_rod = 0;
      m_pts = 0;
      announce(rn[0]);
      step(1'b0, 1'b0, 1'b1);
      stopped = 1'b0;
      for (int r = 0; r < N_R; r++) begin
        play_round(rn[r], rp[r], rft[r], rrst[r], (r + 1 < N_R) ? rn[r + 1] : 0, stopped);
        if (stopped) break;
      end
      if (!stopped) begin
        repeat (4) step(1'($urandom), 1'($urandom), 1'b0);
        chk("fim_state_held", int'(db_estado), 4);
        chk("fim_rodada_held", int'(rodada), N_R);
      end
    end
    repeat (5) step(1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/round_timing_controller.md
ROUND_TIMING_CONTROLLER -- requirements
Module: round_timing_controller

Interface
REQ-001 SHALL have parameter N_RODADAS, default 10, meaning rounds per game (2..15).
REQ-002 SHALL have parameter PAUSA_TICKS, default 500, meaning tick_1ms pulses held in RESULTADO between rounds (1..1023).
REQ-003 SHALL have parameter TOLERANCIA, default 50, meaning max |captured count - mid_idx| scored as a hit.
REQ-004 SHALL have port clock  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports iniciar  input  1  start-game pulse; jogada_feita  input  1  player-press pulse; tick_1ms  input  1  one-cycle time-base enable.
REQ-007 SHALL have port nivel_dificuldade  input  2  difficulty, sampled only in GERA.
REQ-008 SHALL have ports gerar_jogada  output  1  one-cycle new-LED request; trigger  output  1  one-cycle fade-start pulse.
REQ-009 SHALL have ports contador_jogo, mid_idx, max_idx  output  10 each  round count, target index, round length.
REQ-010 SHALL have ports timeout, acerto  output  1 each  one-cycle round-result pulses.
REQ-011 SHALL have ports rodada  output  4  completed-round count; fim_jogo  output  1  game-over level; pontos  output  8  score; db_estado  output  3  FSM state code.

Function
REQ-012 SHALL implement FSM IDLE(0), GERA(1), CONTA(2), RESULTADO(3), FIM(4), encoded on db_estado.
REQ-013 IDLE: iniciar -> GERA; rodada and pontos cleared on that transition.
REQ-014 GERA (one cycle): gerar_jogada=1, contador_jogo cleared, max_idx/mid_idx latched; next state CONTA.
REQ-015 Difficulty table: 00 -> max_idx 800; 01 -> 600; 10 -> 400; 11 -> 400; mid_idx = max_idx >> 1.
REQ-016 trigger SHALL pulse in the first cycle of CONTA (one cycle after gerar_jogada).
REQ-017 CONTA: each tick_1ms increments contador_jogo by 1; no change without tick.
REQ-018 CONTA: jogada_feita -> RESULTADO next cycle, contador_jogo frozen at its current value; acerto pulses in the same transition edge if |contador_jogo - mid_idx| <= TOLERANCIA (10-bit magnitude difference, no wrap).
REQ-019 CONTA: tick_1ms with contador_jogo == max_idx - 1 -> contador_jogo = max_idx, timeout pulses, RESULTADO; contador_jogo never exceeds max_idx.
REQ-020 Simultaneous jogada_feita and terminal tick: jogada_feita wins, count not incremented, no timeout.
REQ-021 RESULTADO: counts PAUSA_TICKS ticks, contador_jogo held; then rodada increments; if new rodada == N_RODADAS -> FIM, else GERA.
REQ-022 FIM: fim_jogo=1, all other pulses 0, outputs held; iniciar -> GERA with rodada/pontos cleared.
REQ-023 iniciar SHALL be ignored in GERA, CONTA, RESULTADO; jogada_feita ignored outside CONTA.
REQ-024 gerar_jogada, trigger, timeout, acerto SHALL never be high more than one consecutive cycle.

Reset
REQ-025 reset SHALL force IDLE next edge, overriding all inputs, from any state including mid-round.
REQ-026 Reset values: contador_jogo 0, max_idx 800, mid_idx 400, rodada 0, pontos 0, all pulses 0, fim_jogo 0, db_estado 0.
REQ-027 Pause counter SHALL be cleared by reset and on every RESULTADO entry.

Configuration
REQ-028 Macro ROUND_SCORE_EN defined: pontos increments by 1 per acerto pulse, saturating at 255.
REQ-029 Macro ROUND_SCORE_EN undefined: scoring logic absent, pontos constant 0; all other behaviour identical.

Verification
REQ-030 Reset, iniciar, nivel 00: gerar_jogada at cycle after iniciar, trigger next cycle, max_idx=800, mid_idx=400.
REQ-031 nivel 01, jogada_feita after 300 ticks: contador_jogo=300, acerto pulse, pontos=1 (SCORE_EN), RESULTADO.
REQ-032 nivel 10, no press: 400 ticks -> contador_jogo=400, timeout pulse once, no acerto, count holds 400 through pause.
REQ-033 jogada_feita same cycle as 400th tick (nivel 10): contador_jogo=399, no timeout, acerto=0 (|399-200|>50).
REQ-034 N_RODADAS=2, PAUSA_TICKS=3: two timed-out rounds -> rodada=2, fim_jogo=1, db_estado=4; iniciar restarts with rodada=0.
REQ-035 reset asserted mid-CONTA at count 123: next cycle db_estado=0, contador_jogo=0, no pulses.
